// File: rtl/arm_multicycle_ctrl.sv
// Multi-cycle ARM control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional MULTICYCLE_PERF_CNT_EN adds cycle and retired-instruction counters.
module arm_multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic [31:0]        Instr,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               BX_ctrl,
    output logic [3:0]         Flags,
    output logic [STATE_W-1:0] state_o
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        retired_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        BXEX   = 4'd10
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_UND = 4'b1000;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic [3:0] cond;
    logic       is_bx;
    logic       cond_ex;
    logic [3:0] alu_op;
    logic       unused;

    assign op     = Instr[27:26];
    assign i_bit  = Instr[25];
    assign cmd    = Instr[24:21];
    assign s_bit  = Instr[20];
    assign cond   = Instr[31:28];
    assign is_bx  = (Instr[27:4] == 24'h12FFF1);
    assign unused = ^Instr[3:0];

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Unsupported cmd encodings go to the ALU as a distinct undefined code.
    always_comb begin
        alu_op = ALU_UND;
        case (cmd)
            ALU_AND, ALU_SUB, ALU_ADD,
            ALU_CMP, ALU_ORR, ALU_MOV: alu_op = cmd;
            default:                  alu_op = ALU_UND;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        flags_d    = flags_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        BX_ctrl    = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                RegSrc     = {op == 2'b01, op == 2'b10};
                if (!cond_ex) begin
                    state_d = FETCH;
                end else if (is_bx) begin
                    state_d = BXEX;
                end else begin
                    case (op)
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        2'b00:   state_d = i_bit ? EXECI : EXECR;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
                state_d    = s_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                RegSrc   = 2'b10;
            end
            EXECR, EXECI: begin
                ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_op;
                if (s_bit || cmd == ALU_CMP) flags_d = ALUFlags;
                state_d    = ALUWB;
            end
            ALUWB: begin
                RegWrite = (cmd != ALU_CMP);
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
            end
            BXEX: begin
                BX_ctrl = 1'b1;
                PCWrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign Flags   = flags_q;
    assign state_o = STATE_W'(state_q);

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 32'd1;
        retired_cnt_d = retired_cnt_q;
        if (state_q != FETCH && state_d == FETCH)
            retired_cnt_d = retired_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cycle_cnt_q   <= 32'd0;
            retired_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl: per-instruction step sequences
// from a reference model, checked cycle by cycle by a separate monitor.
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        RESET;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        BX_ctrl;
    logic [3:0]  Flags;
    logic [3:0]  state_o;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    arm_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .RESET(RESET), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .BX_ctrl(BX_ctrl),
        .Flags(Flags), .state_o(state_o)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw;
        logic [1:0] rs;
        logic       sa;
        logic [1:0] sb;
        logic [3:0] alu;
        logic [1:0] imm;
        logic [1:0] rsrc;
        logic       bx;
        logic [3:0] fl;
    } ov_t;

    ov_t        expq[$];
    int         compared = 0;
    int         mismatched = 0;
    bit         mon_en = 1'b0;
    int         step = 0;
    logic [3:0] flags_m = 4'b0000;

    function automatic bit cond_pass(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'ha: return n == v;
            4'hb: return n != v;
            4'hc: return !z && n == v;
            4'hd: return z || n != v;
            4'he: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic [3:0] c);
        if (c inside {4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101})
            return c;
        return 4'b1000;
    endfunction

    // Expected control word for one step of an instruction.
    function automatic ov_t exp_out(int st, logic [31:0] ins, logic [3:0] fl);
        ov_t o;
        o = '0;
        o.st = 4'(st);
        o.fl = fl;
        case (st)
            0: begin
                o.irw = 1; o.sa = 1; o.sb = 2'd2; o.alu = 4'd4;
                o.rs = 2'd2; o.pcw = 1;
            end
            1: begin
                o.sa = 1; o.sb = 2'd2; o.alu = 4'd4;
                o.rsrc = {ins[27:26] == 2'b01, ins[27:26] == 2'b10};
            end
            2: begin
                o.sb = 2'd1; o.imm = 2'd1;
                o.alu = ins[23] ? 4'd4 : 4'd2;
            end
            3: o.adr = 1;
            4: begin o.rs = 2'd1; o.rw = 1; end
            5: begin o.adr = 1; o.mw = 1; o.rsrc = 2'b10; end
            6, 7: begin
                o.sb = (st == 7) ? 2'd1 : 2'd0;
                o.alu = alu_of(ins[24:21]);
            end
            8: o.rw = (ins[24:21] != 4'b1010);
            9: begin
                o.sa = 1; o.sb = 2'd1; o.imm = 2'd2; o.alu = 4'd4;
                o.rs = 2'd2; o.pcw = 1;
            end
            10: begin o.bx = 1; o.pcw = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue one instruction from FETCH; pushes one expectation per cycle.
    task automatic issue(logic [31:0] ins, logic [3:0] af);
        int seq[$];
        bit wr_fl;
        wr_fl = 0;
        if (!cond_pass(ins[31:28], flags_m))      seq = '{0, 1};
        else if (ins[27:4] == 24'h12FFF1)         seq = '{0, 1, 10};
        else begin
            case (ins[27:26])
                2'b01: seq = ins[20] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
                2'b10: seq = '{0, 1, 9};
                2'b00: begin
                    seq = ins[25] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
                    wr_fl = ins[20] || ins[24:21] == 4'b1010;
                end
                default: seq = '{0, 1};
            endcase
        end
        Instr = ins;
        ALUFlags = af;
        foreach (seq[k]) begin
            expq.push_back(exp_out(seq[k], ins, flags_m));
            if ((seq[k] == 6 || seq[k] == 7) && wr_fl) flags_m = af;
        end
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && expq.size() > 0) begin
            ov_t e, a;
            e = expq.pop_front();
            a = {state_o, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc,
                 BX_ctrl, Flags};
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL step%0d ctrl got=%h exp=%h state got=%0d exp=%0d",
                         step, a, e, a.st, e.st);
            end
            step++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        RESET = 1'b1;
        Instr = 32'h0;
        ALUFlags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_flags", 32'(Flags), 32'd0);
        RESET = 1'b0;
        mon_en = 1'b1;

        repeat (3) issue(32'hE0821003, 4'($urandom));
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("retired_cnt", retired_cnt, 32'd3);
        chk("cycle_cnt", cycle_cnt, 32'd12);
`endif
        issue(32'hE5910004, 4'($urandom));
        issue(32'hE1510001, 4'b0100);
        chk("cmp_flags", 32'(Flags), 32'h4);
        issue(32'h0A000002, 4'($urandom));
        issue(32'h1A000002, 4'($urandom));
        issue(32'hE12FFF1E, 4'($urandom));

        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'he;
            case ($urandom_range(0, 5))
                0, 1: ins[27:26] = 2'b00;
                2:    ins[27:26] = 2'b01;
                3:    ins[27:26] = 2'b10;
                4:    ins[27:4] = 24'h12FFF1;
                default: ins[27:26] = 2'b11;
            endcase
            issue(ins, 4'($urandom));
        end

        issue(32'hE1510001, 4'b1111);
        chk("flags_set", 32'(Flags), 32'hF);
        chk("queue_drained", 32'(expq.size()), 32'd0);

        // Abort a store in its write cycle.
        mon_en = 1'b0;
        Instr = 32'hE5810004;
        repeat (3) @(posedge clk);
        #1;
        chk("memwr_state", 32'(state_o), 32'd5);
        chk("memwr_strobe", 32'(MemWrite), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_flags", 32'(Flags), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(state_o), 32'd0);
        chk("rst_hold_memwrite", 32'(MemWrite), 32'd0);
        RESET = 1'b0;
        flags_m = 4'b0000;
        mon_en = 1'b1;
        issue(32'hE0821003, 4'($urandom));
        issue(32'h0A000002, 4'($urandom));
        chk("final_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
- Moore-style control FSM for the multi-cycle ARM datapath: one shared ALU, one unified instruction/data memory, an instruction register (IR) and a non-architectural ALUOut register.
- Sequences fetch, decode, execute, memory and writeback steps. Evaluates the condition field against an internal NZCV flag register.
- Drives every datapath mux/enable, taking Instr from the IR and ALUFlags from the ALU.

Parameters:
- STATE_W, 4, width of state encoding and of state_o.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-high reset
- Instr  in  32  current IR contents
- ALUFlags  in  4  {N,Z,C,V} from the ALU, same cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = Rm, 01 = extended immediate, 10 = constant 4
- ALUControl  out  4  ALU operation code
- ImmSrc  out  2  extender select: 00 = imm8, 01 = imm12, 10 = imm24 branch
- RegSrc  out  2  [0] = Rn read address is R15; [1] = Rm read address is Rd (STR)
- BX_ctrl  out  1  PC source is Rm
- Flags  out  4  current NZCV register
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Reset: state = FETCH, Flags = 0000. Every output is a pure function of state and Instr, so no output holds a value across reset.
- Decode fields:
  - Op = Instr[27:26]; I = Instr[25]; cmd = Instr[24:21]; S = Instr[20]; L = Instr[20]; Cond = Instr[31:28].
  - BX is detected when Instr[27:4] = 24'h12FFF1.
- CondEx: standard ARM table over Flags.
  - EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V; HI (C & ~Z) and LS; GE (N==V) and LT; GT (~Z & N==V) and LE; AL = 1.
  - Cond 1111 evaluates to 0.
- Any output not listed for a state is 0.
- States (4-bit code) and their outputs:
  - FETCH(0): AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD(0100), ResultSrc=10, PCWrite=1. Next state is DECODE.
  - DECODE(1): ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, so ALUOut = PC+8. RegSrc per Op.
    - Next = FETCH if CondEx=0. Otherwise: BX → BXEX; Op 01 → MEMADR; Op 10 → BRANCH; Op 00 & I → EXECI; Op 00 & ~I → EXECR; Op 11 → FETCH.
  - MEMADR(2): ALUSrcB=01, ImmSrc=01, ALUControl = Instr[23] ? ADD : SUB. Next = L ? MEMRD : MEMWR.
  - MEMRD(3): AdrSrc=1. Next state is MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1. Next state is FETCH.
  - MEMWR(5): AdrSrc=1, MemWrite=1, RegSrc[1]=1. Next state is FETCH.
  - EXECR(6) / EXECI(7): ALUSrcB = 00 / 01, ImmSrc=00, ALUControl=cmd. Next state is ALUWB.
  - ALUWB(8): ResultSrc=00. RegWrite=1 unless cmd=CMP(1010).
  - BRANCH(9): ALUSrcA=1, ALUSrcB=01, ImmSrc=10, ALUControl=ADD, ResultSrc=10, PCWrite=1. Next state is FETCH.
  - BXEX(10): BX_ctrl=1, PCWrite=1. Next state is FETCH.
  - Codes 11–15 are illegal and return to FETCH on the next edge; all outputs are 0 while in them.
- Flags update:
  - Flags <= ALUFlags at the end of EXECR/EXECI when S=1 or cmd=CMP.
  - CMP always writes flags even with S=0.
  - Flags never update in any other state.
- Latency (cycles per instruction):
  - LDR: 5.
  - STR: 4.
  - Data processing (DP): 4.
  - B and BX: 3.
  - Condition-failed or undefined instruction: 2.
- RESET mid-instruction: aborts immediately. No write strobe asserts after RESET rises.
- ALUControl codes: AND 0000, SUB 0010, ADD 0100, CMP 1010, ORR 1100, MOV 1101. Any other cmd → 1000, treated as undefined and passed through.

Optional Feature:
- Macro MULTICYCLE_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0], which increments every cycle RESET is low.
  - Adds retired_cnt[31:0], which increments on every transition into FETCH from a non-FETCH state (condition-failed included).
  - Both counters wrap at 2^32 and clear to 0 on RESET.
- Undefined: the ports and the logic are absent.

Test Plan:
- RESET pulse while in MEMWR → state_o=0 within the same cycle, MemWrite=0, Flags=0000.
- ADD R1,R2,R3 (E0821003) → state sequence 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=0100 in EXECR.
- LDR R0,[R1,#4] (E5910004) → sequence 0,1,2,3,4,0; AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB.
- CMP R1,R1 (E1510001) with ALUFlags=0100 → Flags=0100, no RegWrite. Then BEQ (0A000002) → BRANCH with PCWrite=1. BNE (1A000002) → 0,1,0 with no PCWrite outside FETCH.
- BX R14 (E12FFF1E) → sequence 0,1,10,0; BX_ctrl=1 and PCWrite=1 in BXEX.
- With MULTICYCLE_PERF_CNT_EN, three ADDs after reset → retired_cnt=3, cycle_cnt=12.
